// File: rtl/ysyx_25010008_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : ysyx_25010008_pkg
// Brief  : Shared state encoding and master indices for the IFU/LSU memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package ysyx_25010008_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        ERR  = 2'd3
    } arb_state_e;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ysyx_25010008_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module : ysyx_25010008_mem_arb_if
// Brief  : Request/response bus bundle; master drives requests, slave answers.
// Rev    : 1.0  initial release
// ============================================================================
interface ysyx_25010008_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  req_wen;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_25010008_mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module : ysyx_25010008_arb_pick
// Brief  : Two-requester winner select; round-robin when YSYX_25010008_ARB_RR_EN
//          is defined, otherwise fixed priority with the LSU winning ties.
// Rev    : 1.0  initial release
// ============================================================================
module ysyx_25010008_arb_pick
    import ysyx_25010008_pkg::*;
(
    input  wire logic [1:0] i_req,
    input  wire logic       i_last,
    output logic      [1:0] o_gnt
);

`ifdef YSYX_25010008_ARB_RR_EN
    // On a tie the master that did not win last time goes first.
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = (i_last == M_LSU) ? 2'b01 : 2'b10;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last;

    always_comb begin
        o_gnt = i_req;
        if (i_req[M_LSU]) begin
            o_gnt = 2'b10;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/ysyx_25010008_mem_arb.sv
`default_nettype none
// ============================================================================
// Module : ysyx_25010008_mem_arb
// Brief  : Single-outstanding IFU/LSU arbiter onto one memory port with response
//          timeout; YSYX_25010008_ARB_RR_EN selects round-robin arbitration.
// Rev    : 1.0  initial release
// ============================================================================
module ysyx_25010008_mem_arb
    import ysyx_25010008_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input wire logic clk,
    input wire logic rst,
    ysyx_25010008_mem_arb_if.slave  m0,
    ysyx_25010008_mem_arb_if.slave  m1,
    ysyx_25010008_mem_arb_if.master s
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic                r_gnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;
    logic [15:0]         r_cnt;
    logic [15:0]         w_cnt_inc;
    logic [1:0]          w_pick;
    logic                w_last;
    logic                w_grant;
    logic                w_rsp_ready_g;
    logic                w_unused_m0;

    // The IFU only reads, so its write-side fields are never forwarded.
    assign w_unused_m0   = ^{m0.req_wen, m0.req_wdata, m0.req_wmask};
    assign w_cnt_inc     = r_cnt + 16'd1;
    assign w_grant       = (r_state == IDLE) && (|w_pick);
    assign w_rsp_ready_g = r_gnt ? m1.rsp_ready : m0.rsp_ready;

`ifdef YSYX_25010008_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= M_LSU;
        end else if (w_grant) begin
            r_last <= w_pick[M_LSU];
        end
    end

    assign w_last = r_last;
`else
    assign w_last = M_LSU;
`endif

    ysyx_25010008_arb_pick u_pick (
        .i_req  ({m1.req_valid, m0.req_valid}),
        .i_last (w_last),
        .o_gnt  (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (|w_pick) w_state_nxt = REQ;
            REQ:  if (s.req_ready) w_state_nxt = RSP;
            RSP: begin
                if (s.rsp_valid) begin
                    if (w_rsp_ready_g) w_state_nxt = IDLE;
                end else if (w_cnt_inc == 16'(TIMEOUT_CYC)) begin
                    w_state_nxt = ERR;
                end
            end
            ERR:  if (w_rsp_ready_g) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt   <= M_IFU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_grant) begin
                r_gnt <= w_pick[M_LSU];
                if (w_pick[M_LSU]) begin
                    r_addr  <= m1.req_addr;
                    r_wen   <= m1.req_wen;
                    r_wdata <= m1.req_wdata;
                    r_wmask <= m1.req_wmask;
                end else begin
                    r_addr  <= m0.req_addr;
                    r_wen   <= 1'b0;
                    r_wdata <= '0;
                    r_wmask <= '0;
                end
            end
            // Counts only silent RSP cycles; a stalled-but-valid response does not age.
            if ((r_state == REQ) && s.req_ready) begin
                r_cnt <= '0;
            end else if ((r_state == RSP) && !s.rsp_valid) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign s.req_addr  = r_addr;
    assign s.req_wen   = r_wen;
    assign s.req_wdata = r_wdata;
    assign s.req_wmask = r_wmask;

    always_comb begin
        m0.req_ready = 1'b0;
        m1.req_ready = 1'b0;
        m0.rsp_valid = 1'b0;
        m0.rsp_data  = '0;
        m0.rsp_err   = 1'b0;
        m1.rsp_valid = 1'b0;
        m1.rsp_data  = '0;
        m1.rsp_err   = 1'b0;
        s.req_valid  = 1'b0;
        s.rsp_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                m0.req_ready = w_pick[M_IFU];
                m1.req_ready = w_pick[M_LSU];
            end
            REQ: s.req_valid = 1'b1;
            RSP: begin
                s.rsp_ready = w_rsp_ready_g;
                if (r_gnt) begin
                    m1.rsp_valid = s.rsp_valid;
                    m1.rsp_data  = s.rsp_data;
                    m1.rsp_err   = s.rsp_err;
                end else begin
                    m0.rsp_valid = s.rsp_valid;
                    m0.rsp_data  = s.rsp_data;
                    m0.rsp_err   = s.rsp_err;
                end
            end
            ERR: begin
                // Memory is always drained here so a late reply cannot leak out.
                s.rsp_ready = 1'b1;
                if (r_gnt) begin
                    m1.rsp_valid = 1'b1;
                    m1.rsp_err   = 1'b1;
                end else begin
                    m0.rsp_valid = 1'b1;
                    m0.rsp_err   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25010008_mem_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_ysyx_25010008_mem_arb
// Brief  : Self-checking bench for the IFU/LSU memory arbiter (both arbitration builds).
// Rev    : 1.0  initial release
// ============================================================================
module tb_ysyx_25010008_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int TO = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   mdl_last;

    logic [AW-1:0] p_addr  [2];
    logic          p_wen   [2];
    logic [DW-1:0] p_wdata [2];
    logic [MW-1:0] p_wmask [2];

    ysyx_25010008_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) u_m0 ();
    ysyx_25010008_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) u_m1 ();
    ysyx_25010008_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) u_s  ();

    ysyx_25010008_mem_arb #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .m0  (u_m0),
        .m1  (u_m1),
        .s   (u_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Arbitration rule: a lone requester wins; ties follow the build's policy.
    function automatic int exp_pick(input bit r0, input bit r1, input int last);
`ifdef YSYX_25010008_ARB_RR_EN
        if (r0 && r1) return (last == 1) ? 0 : 1;
`else
        if (r0 && r1) return 1;
`endif
        return r1 ? 1 : 0;
    endfunction

    function automatic logic gv(input int w);
        return (w == 1) ? u_m1.rsp_valid : u_m0.rsp_valid;
    endfunction
    function automatic logic [DW-1:0] gd(input int w);
        return (w == 1) ? u_m1.rsp_data : u_m0.rsp_data;
    endfunction
    function automatic logic ge(input int w);
        return (w == 1) ? u_m1.rsp_err : u_m0.rsp_err;
    endfunction
    function automatic logic ov(input int w);
        return (w == 1) ? u_m0.rsp_valid : u_m1.rsp_valid;
    endfunction

    task automatic set_rdy(input int w, input logic v);
        if (w == 1) u_m1.rsp_ready = v;
        else        u_m0.rsp_ready = v;
    endtask

    task automatic set_req(input int idx, input logic [AW-1:0] a, input logic we,
                           input logic [DW-1:0] wd, input logic [MW-1:0] wm);
        p_addr[idx] = a; p_wen[idx] = we; p_wdata[idx] = wd; p_wmask[idx] = wm;
        if (idx == 1) begin
            u_m1.req_addr = a; u_m1.req_wen = we; u_m1.req_wdata = wd; u_m1.req_wmask = wm;
            u_m1.req_valid = 1'b1;
        end else begin
            u_m0.req_addr = a; u_m0.req_wen = we; u_m0.req_wdata = wd; u_m0.req_wmask = wm;
            u_m0.req_valid = 1'b1;
        end
    endtask

    // One full transaction for expected winner w: wr stall cycles on s_req_ready,
    // lat silent response cycles (lat >= TO means the memory never answers).
    task automatic serve(input int w, input int wr, input int lat,
                         input logic [DW-1:0] rd, input logic re);
        int got;
        logic [AW+DW+MW:0] exp_f;
        logic [AW+DW+MW:0] act_f;
        got = -1;
        if (w == 1) exp_f = {p_addr[1], p_wen[1], p_wdata[1], p_wmask[1]};
        else        exp_f = {p_addr[0], 1'b0, {DW{1'b0}}, {MW{1'b0}}};
        for (int i = 0; i < 8 && got < 0; i++) begin
            @(negedge clk);
            if (u_m0.req_ready && u_m1.req_ready) got = 2;
            else if (u_m1.req_ready)              got = 1;
            else if (u_m0.req_ready)              got = 0;
        end
        n_vec++;
        if (got != w) begin
            $display("FAIL grant: granted master %0d, expected %0d", got, w);
            n_err++;
        end
        if (got < 0) return;
        tick;
        if (got == 1) u_m1.req_valid = 1'b0;
        else          u_m0.req_valid = 1'b0;
        mdl_last = w;
        for (int k = 0; k <= wr; k++) begin
            u_s.req_ready = (k == wr);
            @(negedge clk);
            act_f = {u_s.req_addr, u_s.req_wen, u_s.req_wdata, u_s.req_wmask};
            n_vec++;
            if (u_s.req_valid !== 1'b1 || act_f !== exp_f) begin
                $display("FAIL s_req cyc%0d: valid=%b fields=%h, expected valid=1 fields=%h",
                         k, u_s.req_valid, act_f, exp_f);
                n_err++;
            end
            tick;
        end
        u_s.req_ready = 1'b0;
        for (int c = 0; c < lat && c < TO; c++) begin
            set_rdy(w, logic'(c % 2));
            @(negedge clk);
            n_vec++;
            if (gv(w) !== 1'b0 || ov(w) !== 1'b0 || u_s.rsp_ready !== logic'(c % 2)) begin
                $display("FAIL rsp_wait cyc%0d: vld=%b other=%b s_rdy=%b, expected 0 0 %0d",
                         c, gv(w), ov(w), u_s.rsp_ready, c % 2);
                n_err++;
            end
            tick;
        end
        set_rdy(w, 1'b1);
        if (lat < TO) begin
            u_s.rsp_valid = 1'b1; u_s.rsp_data = rd; u_s.rsp_err = re;
            @(negedge clk);
            n_vec++;
            if ({gv(w), gd(w), ge(w), ov(w), u_s.rsp_ready} !== {1'b1, rd, re, 1'b0, 1'b1}) begin
                $display("FAIL rsp: vld=%b data=%h err=%b other=%b s_rdy=%b, expected 1 %h %b 0 1",
                         gv(w), gd(w), ge(w), ov(w), u_s.rsp_ready, rd, re);
                n_err++;
            end
            tick;
            u_s.rsp_valid = 1'b0;
        end else begin
            u_s.rsp_valid = 1'b1; u_s.rsp_data = $urandom; u_s.rsp_err = 1'b0;
            set_rdy(w, 1'b0);
            for (int e = 0; e < 2; e++) begin
                @(negedge clk);
                n_vec++;
                if ({gv(w), gd(w), ge(w), ov(w), u_s.rsp_ready} !== {1'b1, {DW{1'b0}}, 1'b1, 1'b0, 1'b1}) begin
                    $display("FAIL timeout cyc%0d: vld=%b data=%h err=%b other=%b s_rdy=%b, expected 1 0 1 0 1",
                             e, gv(w), gd(w), ge(w), ov(w), u_s.rsp_ready);
                    n_err++;
                end
                tick;
                u_s.rsp_valid = 1'b0;
                set_rdy(w, 1'b1);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        u_m0.req_valid = 1'b0; u_m0.req_addr = '0; u_m0.req_wen = 1'b0;
        u_m0.req_wdata = '0; u_m0.req_wmask = '0; u_m0.rsp_ready = 1'b1;
        u_m1.req_valid = 1'b0; u_m1.req_addr = '0; u_m1.req_wen = 1'b0;
        u_m1.req_wdata = '0; u_m1.req_wmask = '0; u_m1.rsp_ready = 1'b1;
        u_s.req_ready = 1'b0; u_s.rsp_valid = 1'b0; u_s.rsp_data = '0; u_s.rsp_err = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        mdl_last = 1;
        @(negedge clk);
        n_vec++;
        if ({u_m0.req_ready, u_m1.req_ready, u_m0.rsp_valid, u_m1.rsp_valid,
             u_s.req_valid, u_s.rsp_ready} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {u_m0.req_ready, u_m1.req_ready, u_m0.rsp_valid, u_m1.rsp_valid,
                      u_s.req_valid, u_s.rsp_ready});
            n_err++;
        end
        n_vec++;
        if ({u_s.req_addr, u_s.req_wen, u_s.req_wdata, u_s.req_wmask} !== '0) begin
            $display("FAIL reset_fields: got %h, expected 0",
                     {u_s.req_addr, u_s.req_wen, u_s.req_wdata, u_s.req_wmask});
            n_err++;
        end
        tick;
        // Tie straight after reset exposes the reset value of the last-grant pointer.
        set_req(0, 32'h8000_0100, 1'b1, 32'h1111_2222, 4'h3);
        set_req(1, 32'h8000_0200, 1'b0, 32'h3333_4444, 4'h0);
        serve(exp_pick(1'b1, 1'b1, mdl_last), 0, 0, 32'hAAAA_0001, 1'b0);
        serve(1 - mdl_last, 0, 0, 32'hAAAA_0002, 1'b0);
    endtask

    task automatic test_ifu_read;
        set_req(0, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 4'hF);
        serve(0, 0, 2, 32'h0000_0413, 1'b0);
    endtask

    task automatic test_tie;
        set_req(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0);
        set_req(1, 32'h8000_0020, 1'b0, 32'h0, 4'h0);
        serve(1, 0, 0, 32'h0000_0020, 1'b0);
        set_req(1, 32'h8000_0024, 1'b1, 32'h5555_6666, 4'hC);
`ifdef YSYX_25010008_ARB_RR_EN
        serve(0, 0, 0, 32'h0000_0010, 1'b0);
        serve(1, 0, 0, 32'h0000_0024, 1'b1);
`else
        serve(1, 0, 0, 32'h0000_0024, 1'b1);
        serve(0, 0, 0, 32'h0000_0010, 1'b0);
`endif
    endtask

    task automatic test_write_hold;
        set_req(1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
        serve(1, 3, 0, 32'h0, 1'b0);
    endtask

    task automatic test_timeout;
        set_req(1, 32'h8000_3000, 1'b0, 32'h0, 4'h0);
        serve(1, 0, TO + 1, 32'h0, 1'b0);
        set_req(0, 32'h8000_3004, 1'b0, 32'h0, 4'h0);
        serve(0, 0, 0, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_rst_mid;
        set_req(0, 32'h8000_2000, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        n_vec++;
        if (u_m0.req_ready !== 1'b1) begin
            $display("FAIL rstmid_grant: m0_req_ready=%b, expected 1", u_m0.req_ready);
            n_err++;
        end
        tick;
        u_m0.req_valid = 1'b0;
        u_s.req_ready  = 1'b1;
        tick;
        u_s.req_ready  = 1'b0;
        @(negedge clk);
        n_vec++;
        if (u_s.rsp_ready !== 1'b1 || u_s.req_valid !== 1'b0) begin
            $display("FAIL rstmid_in_rsp: s_rsp_ready=%b s_req_valid=%b, expected 1 0",
                     u_s.rsp_ready, u_s.req_valid);
            n_err++;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        mdl_last = 1;
        @(negedge clk);
        n_vec++;
        if ({u_m0.req_ready, u_m1.req_ready, u_m0.rsp_valid, u_m1.rsp_valid,
             u_s.req_valid, u_s.rsp_ready, u_s.req_addr} !== '0) begin
            $display("FAIL rstmid_outputs: got %h, expected 0",
                     {u_m0.req_ready, u_m1.req_ready, u_m0.rsp_valid, u_m1.rsp_valid,
                      u_s.req_valid, u_s.rsp_ready, u_s.req_addr});
            n_err++;
        end
        tick;
        set_req(0, 32'h8000_2004, 1'b0, 32'h0, 4'h0);
        serve(0, 0, 1, 32'h0BAD_F00D, 1'b0);
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            int r;
            int first;
            r = $urandom_range(1, 3);
            if (r[0]) set_req(0, $urandom, 1'($urandom), $urandom, 4'($urandom));
            if (r[1]) set_req(1, $urandom, 1'($urandom), $urandom, 4'($urandom));
            first = exp_pick(r[0], r[1], mdl_last);
            serve(first, $urandom_range(0, 2), $urandom_range(0, 5), $urandom, 1'($urandom));
            if (r == 3) begin
                serve(1 - first, $urandom_range(0, 2), $urandom_range(0, 5), $urandom, 1'($urandom));
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        mdl_last = 1;
        test_reset;
        test_ifu_read;
        test_tie;
        test_write_hold;
        test_timeout;
        test_rst_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
